// File: rtl/uart_dump_ctrl_pkg.sv
// Shared definitions for the UART frame-dump controller.
//   - Command bytes recognised on the UART receive path.
//   - Controller FSM state encoding.
//   - Bit positions inside the status byte returned for CMD_STAT.
package uart_dump_ctrl_pkg;

  localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_STAT  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_ABORT = 8'h58;  // 'X'

  localparam int STAT_OVERRUN_BIT = 0;
  localparam int STAT_ABORTED_BIT = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    SEND = 3'd3,
    TXW  = 3'd4,
    STAT = 3'd5
  } state_e;

  function automatic logic [7:0] status_byte(input logic aborted, input logic overrun);
    logic [7:0] b;
    b = 8'h00;
    b[STAT_ABORTED_BIT] = aborted;
    b[STAT_OVERRUN_BIT] = overrun;
    return b;
  endfunction

endpackage

// File: rtl/uart_dump_ctrl_tx_handshake.sv
// uart_tx_handshake: start/complete handshake towards a UART transmitter.
// Shared by the dump, status and echo paths of uart_dump_ctrl.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   send_i      owner FSM is in its SEND state
//   txw_i       owner FSM is in its TXW state
//   tx_busy_i   transmitter busy
//   fire_o      SEND may leave this cycle (transmitter idle)
//   done_o      TXW may leave this cycle (transmission finished)
//   tx_start_o  registered one-cycle start strobe to the transmitter
// Handshake: tx_start_o is high for exactly the first TXW cycle. tx_busy_i
// is not trusted while tx_start_o is high nor in the following cycle, so a
// transmitter that raises busy one cycle after seeing the strobe is never
// mistaken for one that has already finished.
module uart_tx_handshake (
  input  logic clk,
  input  logic rst,
  input  logic send_i,
  input  logic txw_i,
  input  logic tx_busy_i,
  output logic fire_o,
  output logic done_o,
  output logic tx_start_o
);

  logic start_q;
  logic guard_q;

  assign fire_o     = send_i && !tx_busy_i;
  assign done_o     = txw_i && !start_q && !guard_q && !tx_busy_i;
  assign tx_start_o = start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      guard_q <= 1'b0;
    end else begin
      start_q <= fire_o;
      guard_q <= start_q;
    end
  end

endmodule

// File: rtl/uart_dump_ctrl.sv
// uart_dump_ctrl: dumps a frame RAM over a UART on command.
//   'D' dumps DUMP_LEN bytes from addresses 0..DUMP_LEN-1, 'X' aborts a dump
//   after the byte in flight, 'S' returns {6'b0, aborted, overrun}.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx_valid/rx_data  received byte strobe and data
//   tx_busy           transmitter busy
//   tx_start/tx_data  transmit strobe and byte (stable until tx_busy falls)
//   ram_rd_en/addr    RAM read strobe and address
//   ram_rd_data       RAM data, one cycle after ram_rd_en
//   frame_lock        high while a dump is in progress
//   busy              high whenever the FSM is not IDLE
// Configuration: define UART_DUMP_ECHO_EN to echo unknown bytes received in
// IDLE; otherwise they are ignored.
module uart_dump_ctrl
  import uart_dump_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int DUMP_LEN = 19200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rd_data,
  output logic              frame_lock,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              lock_q, lock_d;          // dump in progress
  logic              aborted_q, aborted_d;
  logic              overrun_q, overrun_d;
  logic              abort_pend_q, abort_pend_d;

  logic hs_fire;
  logic hs_done;
  logic abort_now;

  uart_tx_handshake u_hs (
    .clk       (clk),
    .rst       (rst),
    .send_i    (state_q == SEND),
    .txw_i     (state_q == TXW),
    .tx_busy_i (tx_busy),
    .fire_o    (hs_fire),
    .done_o    (hs_done),
    .tx_start_o(tx_start)
  );

  // An 'X' arriving in the very cycle TXW finishes still ends the dump.
  assign abort_now = abort_pend_q || (rx_valid && lock_q && (rx_data == CMD_ABORT));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tx_data_d    = tx_data_q;
    lock_d       = lock_q;
    aborted_d    = aborted_q;
    overrun_d    = overrun_q;
    abort_pend_d = abort_pend_q;

    // Bytes arriving outside IDLE: only 'X' during a dump means anything.
    if (rx_valid && (state_q != IDLE)) begin
      if (lock_q && (rx_data == CMD_ABORT)) begin
        abort_pend_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_DUMP) begin
            addr_d       = '0;
            aborted_d    = 1'b0;
            overrun_d    = 1'b0;
            abort_pend_d = 1'b0;
            lock_d       = 1'b1;
            state_d      = RD;
          end else if (rx_data == CMD_STAT) begin
            state_d = STAT;
          end else begin
`ifdef UART_DUMP_ECHO_EN
            tx_data_d = rx_data;
            state_d   = SEND;
`endif
          end
        end
      end
      RD: state_d = RDW;
      RDW: begin
        tx_data_d = ram_rd_data;
        state_d   = SEND;
      end
      STAT: begin
        tx_data_d = status_byte(aborted_q, overrun_q);
        state_d   = SEND;
      end
      SEND: begin
        if (hs_fire) state_d = TXW;
      end
      TXW: begin
        if (hs_done) begin
          if (lock_q && (addr_q != LAST_ADDR) && !abort_now) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = RD;
          end else begin
            if (lock_q && abort_now) aborted_d = 1'b1;
            abort_pend_d = 1'b0;
            lock_d       = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      tx_data_q    <= 8'h00;
      lock_q       <= 1'b0;
      aborted_q    <= 1'b0;
      overrun_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tx_data_q    <= tx_data_d;
      lock_q       <= lock_d;
      aborted_q    <= aborted_d;
      overrun_q    <= overrun_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign ram_rd_en  = (state_q == RD);
  assign ram_addr   = addr_q;
  assign frame_lock = lock_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_dump_ctrl.sv
// Bench for uart_dump_ctrl. Two instances share clock and reset: dut0 with
// DUMP_LEN=4 and dut1 with DUMP_LEN=8. Expected transmit bytes are queued as
// {frame_lock, instance, byte} when a command is issued; a monitor pops them
// on every tx_start and also plays the UART transmitter (tx_busy).
// Build with UART_DUMP_ECHO_EN defined to exercise the echo variant.
module tb_uart_dump_ctrl;

  localparam int AW = 4;

  logic       clk;
  logic       rst;
  logic       rx_valid    [2];
  logic [7:0] rx_data     [2];
  logic       tx_busy     [2];
  logic [7:0] ram_rd_data [2];
  logic       tx_start    [2];
  logic [7:0] tx_data     [2];
  logic       ram_rd_en   [2];
  logic [AW-1:0] ram_addr [2];
  logic       frame_lock  [2];
  logic       busy        [2];

  logic [7:0] mem [2][16];
  logic [9:0] exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   tx_seen  [2];
  int   busy_cnt [2];
  logic [7:0] cur_exp [2];
  logic stable_bad [2];
  int   tx_len = 4;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_dump_ctrl #(.ADDR_W(AW), .DUMP_LEN(4)) dut0 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid[0]), .rx_data(rx_data[0]),
    .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .ram_rd_en(ram_rd_en[0]), .ram_addr(ram_addr[0]), .ram_rd_data(ram_rd_data[0]),
    .frame_lock(frame_lock[0]), .busy(busy[0])
  );

  uart_dump_ctrl #(.ADDR_W(AW), .DUMP_LEN(8)) dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid[1]), .rx_data(rx_data[1]),
    .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .ram_rd_en(ram_rd_en[1]), .ram_addr(ram_addr[1]), .ram_rd_data(ram_rd_data[1]),
    .frame_lock(frame_lock[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous RAM: data only valid the cycle after a read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      ram_rd_data[i] <= ram_rd_en[i] ? mem[i][ram_addr[i]] : 8'hEE;
  end

  // ---------------- monitor / scoreboard + transmitter model ----------------
  initial begin : monitor
    logic [9:0] e;
    for (int i = 0; i < 2; i++) begin
      tx_busy[i] = 1'b0; busy_cnt[i] = 0; tx_seen[i] = 0;
      stable_bad[i] = 1'b0; cur_exp[i] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          tx_busy[i] = 1'b0;
          busy_cnt[i] = 0;
        end else if (tx_start[i]) begin
          tx_seen[i]++;
          check("start_while_busy", 32'(tx_busy[i]), 0);
          check("unexpected_tx_start", 32'(exp_q.size() == 0), 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_dev", i, 32'(e[8]));
            check("tx_data", 32'(tx_data[i]), 32'(e[7:0]));
            check("frame_lock_at_tx", 32'(frame_lock[i]), 32'(e[9]));
            cur_exp[i] = e[7:0];
          end
          stable_bad[i] = 1'b0;
          tx_busy[i] = 1'b1;
          busy_cnt[i] = tx_len;
        end else if (tx_busy[i]) begin
          if (tx_data[i] !== cur_exp[i]) stable_bad[i] = 1'b1;
          busy_cnt[i]--;
          if (busy_cnt[i] == 0) begin
            tx_busy[i] = 1'b0;
            check("tx_data_stable", 32'(stable_bad[i]), 0);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input int i, input logic [7:0] b);
    rx_data[i] = b;
    rx_valid[i] = 1'b1;
    @(negedge clk);
    rx_valid[i] = 1'b0;
    rx_data[i] = 8'h00;
  endtask

  task automatic push_dump(input int i, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({1'b1, (i == 1), mem[i][k]});
  endtask

  task automatic push_status(input int i, input logic abt, input logic ovr);
    logic [7:0] s;
    s = 8'(2 * int'(abt) + int'(ovr));
    exp_q.push_back({1'b0, (i == 1), s});
  endtask

  task automatic wait_seen(input int i, input int n);
    int t;
    t = 0;
    while (tx_seen[i] < n && t < 3000) begin @(negedge clk); t++; end
    check("wait_seen_timeout", 32'(t >= 3000), 0);
  endtask

  task automatic wait_idle(input int i);
    int t;
    t = 0;
    while ((busy[i] || tx_busy[i] || exp_q.size() != 0) && t < 4000) begin
      @(negedge clk); t++;
    end
    check("wait_idle_timeout", 32'(t >= 4000), 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int base;
    int abort_at, junk_at, nsent;
    logic do_junk;
    logic [7:0] jb;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin rx_valid[i] = 1'b0; rx_data[i] = 8'h00; end
    for (int i = 0; i < 2; i++) for (int k = 0; k < 16; k++) mem[i][k] = 8'($urandom_range(0, 255));
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_tx_start", 32'(tx_start[0]), 0);
    check("rst_tx_data", 32'(tx_data[0]), 0);
    check("rst_ram_rd_en", 32'(ram_rd_en[0]), 0);
    check("rst_ram_addr", 32'(ram_addr[0]), 0);
    check("rst_frame_lock", 32'(frame_lock[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_busy1", 32'(busy[1]), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Four-byte dump with fixed contents.
    mem[0][0] = 8'h11; mem[0][1] = 8'h22; mem[0][2] = 8'h33; mem[0][3] = 8'h44;
    tx_len = 3;
    base = tx_seen[0];
    push_dump(0, 4);
    send_byte(0, 8'h44);
    check("lock_after_d", 32'(frame_lock[0]), 1);
    wait_idle(0);
    check("dump4_count", tx_seen[0] - base, 4);
    check("dump4_lock_drop", 32'(frame_lock[0]), 0);
    check("dump4_busy", 32'(busy[0]), 0);

    // Slow transmitter: busy held 50 cycles per byte.
    for (int k = 0; k < 4; k++) mem[0][k] = 8'($urandom_range(0, 255));
    tx_len = 50;
    base = tx_seen[0];
    push_dump(0, 4);
    send_byte(0, 8'h44);
    wait_idle(0);
    check("slow_count", tx_seen[0] - base, 4);

    // Abort while byte 2 is in flight.
    tx_len = 5;
    base = tx_seen[1];
    push_dump(1, 3);
    send_byte(1, 8'h44);
    wait_seen(1, base + 3);
    send_byte(1, 8'h58);
    wait_idle(1);
    check("abort_count", tx_seen[1] - base, 3);
    check("abort_lock_drop", 32'(frame_lock[1]), 0);
    push_status(1, 1'b1, 1'b0);
    send_byte(1, 8'h53);
    wait_idle(1);

    // Stray byte during a dump -> overrun.
    base = tx_seen[1];
    push_dump(1, 8);
    send_byte(1, 8'h44);
    wait_seen(1, base + 2);
    send_byte(1, 8'h41);
    wait_idle(1);
    check("ovr_count", tx_seen[1] - base, 8);
    push_status(1, 1'b0, 1'b1);
    send_byte(1, 8'h53);
    wait_idle(1);

    // Reset during TXW of byte 1.
    tx_len = 6;
    base = tx_seen[1];
    push_dump(1, 2);
    send_byte(1, 8'h44);
    wait_seen(1, base + 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_start", 32'(tx_start[1]), 0);
    check("mid_rst_tx_data", 32'(tx_data[1]), 0);
    check("mid_rst_ram_rd_en", 32'(ram_rd_en[1]), 0);
    check("mid_rst_ram_addr", 32'(ram_addr[1]), 0);
    check("mid_rst_frame_lock", 32'(frame_lock[1]), 0);
    check("mid_rst_busy", 32'(busy[1]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_more_tx", tx_seen[1] - base, 2);
    base = tx_seen[1];
    push_dump(1, 8);
    send_byte(1, 8'h44);
    wait_idle(1);
    check("restart_count", tx_seen[1] - base, 8);
    push_status(1, 1'b0, 1'b0);
    send_byte(1, 8'h53);
    wait_idle(1);

    // Unknown command in IDLE.
    tx_len = 3;
    base = tx_seen[0];
`ifdef UART_DUMP_ECHO_EN
    exp_q.push_back({1'b0, 1'b0, 8'h51});
`endif
    send_byte(0, 8'h51);
    repeat (5) @(negedge clk);
    wait_idle(0);
`ifdef UART_DUMP_ECHO_EN
    check("echo_count", tx_seen[0] - base, 1);
`else
    check("ignore_count", tx_seen[0] - base, 0);
`endif
    push_status(0, 1'b0, 1'b0);
    send_byte(0, 8'h53);
    wait_idle(0);

    // Randomized dumps with optional stray byte and optional abort.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) mem[1][k] = 8'($urandom_range(0, 255));
      tx_len = $urandom_range(4, 7);
      abort_at = $urandom_range(0, 8);
      nsent = (abort_at == 8) ? 8 : abort_at + 1;
      do_junk = 1'($urandom_range(0, 1));
      junk_at = $urandom_range(0, nsent - 1);
      jb = 8'($urandom_range(0, 255));
      if (jb == 8'h58) jb = 8'h59;
      base = tx_seen[1];
      push_dump(1, nsent);
      send_byte(1, 8'h44);
      if (do_junk) begin
        wait_seen(1, base + junk_at + 1);
        send_byte(1, jb);
      end
      if (abort_at < 8) begin
        wait_seen(1, base + abort_at + 1);
        send_byte(1, 8'h58);
      end
      wait_idle(1);
      check("rand_count", tx_seen[1] - base, nsent);
      push_status(1, (abort_at < 8), do_junk);
      send_byte(1, 8'h53);
      wait_idle(1);
    end

    repeat (5) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_dump_ctrl.md
UART_DUMP_CTRL -- requirements
Module: uart_dump_ctrl

Interface
REQ-001 Parameter ADDR_W, default 15: frame RAM address width.
REQ-002 Parameter DUMP_LEN, default 19200: bytes sent per dump; SHALL satisfy 1 <= DUMP_LEN <= 2**ADDR_W.
REQ-003 Ports SHALL be:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- rx_valid  in  1  one-cycle strobe, byte received.
- rx_data  in  8  received byte, valid with rx_valid.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle strobe, send tx_data.
- tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls.
- ram_rd_en  out  1  RAM read strobe.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rd_data  in  8  RAM data, valid exactly 1 cycle after ram_rd_en.
- frame_lock  out  1  high during dump; camera writer pauses.
- busy  out  1  high in any state other than IDLE.

Function
REQ-004 FSM states SHALL be IDLE, RD, RDW, SEND, TXW and STAT.
REQ-005 IDLE SHALL handle rx_valid as follows:
- 0x44 ('D'): clear addr to 0, clear abort/overrun flags, go to RD.
- 0x53 ('S'): go to STAT.
- Any other byte: handled per REQ-016.
REQ-006 RD SHALL drive ram_rd_en=1 with ram_addr=addr for one cycle, then go to RDW.
REQ-007 RDW SHALL register ram_rd_data into tx_data, then go to SEND.
REQ-008 SEND SHALL wait while tx_busy=1; on the first cycle with tx_busy=0 it SHALL pulse tx_start for one cycle and go to TXW.
REQ-009 TXW SHALL ignore tx_busy in the cycle after tx_start, then wait for tx_busy=0. On exit:
- addr==DUMP_LEN-1, or abort pending: go to IDLE.
- Otherwise: addr+1, go to RD.
REQ-010 Exactly DUMP_LEN bytes, addresses 0..DUMP_LEN-1 in ascending order, SHALL be sent for an unaborted dump. addr SHALL never wrap.
REQ-011 During a dump, rx_valid handling SHALL be:
- 0x58 ('X'): set abort pending; the byte in flight completes, then go to IDLE with aborted=1.
- Any other byte: set overrun=1 and discard the byte.
REQ-012 STAT SHALL load tx_data={6'b0, aborted, overrun}, then send it using the SEND/TXW handshake, then return to IDLE. rx bytes received meanwhile SHALL be discarded and set overrun.
REQ-013 frame_lock SHALL be high from the cycle after 'D' is accepted until the cycle IDLE is re-entered.
REQ-014 When rx_valid coincides with a state transition, the byte SHALL be interpreted in the state being left.

Reset
REQ-015 rst SHALL asynchronously force:
- state=IDLE.
- addr=0, tx_data=0x00.
- tx_start=0, ram_rd_en=0, frame_lock=0, busy=0.
- aborted=0, overrun=0.
Reset mid-dump SHALL abandon the dump without any further tx_start.

Configuration
REQ-016 Macro UART_DUMP_ECHO_EN:
- Defined: IDLE SHALL echo any byte other than 'D'/'S' through SEND/TXW.
- Undefined: such bytes SHALL be ignored and flags left unchanged.

Structure
REQ-017 A shared package SHALL hold:
- Command constants CMD_DUMP=0x44, CMD_STAT=0x53, CMD_ABORT=0x58.
- The FSM state enum.
- The status-byte bit positions.
REQ-018 The SEND/TXW handshake SHALL be a sub-module uart_tx_handshake, reused by dump, status and echo.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- DUMP_LEN=4, RAM[0..3]=11,22,33,44, rx 'D' -> tx bytes 11,22,33,44 in order; frame_lock drops after the 4th; busy=0.
- tx_busy held high 50 cycles after tx_start -> no new tx_start until tx_busy=0; tx_data stable throughout.
- DUMP_LEN=8, 'X' sent while byte 2 is in flight -> exactly 3 bytes sent; next 'S' -> status 0x02.
- 'A' during dump -> discarded; after dump completes, 'S' -> 0x01.
- rst asserted in TXW of byte 1 -> all outputs reach reset values immediately; no further tx_start; a subsequent 'D' restarts at addr 0.
- 'Q' in IDLE -> with UART_DUMP_ECHO_EN, tx 0x51; without it, no tx_start.
